slave_rr_arbiter: RTL and testbench

- Shares one single-register `slave` endpoint between NM crossbar masters.
- Per-master req/cmd/wdata/rdata/ack ports on one side; a single slave-facing req/cmd/wdata/rdata/ack port on the other.
- Round-robin arbitration; one transaction in flight at a time.
- Enforces the slave's inter-transaction idle gap, so back-to-back requests never hit the slave while its ack-edge detector is still set.

---
 rtl/slave_rr_arbiter.sv | 175 +++++++++++++++++
 tb/tb_slave_rr_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/slave_rr_arbiter.sv
// Purpose : round-robin share of one single-register slave between NM masters, one transaction in flight.
// Latency : m_req_i cycle 0 -> s_req_o cycle 1 -> s_ack_i cycle 2 -> m_ack_o/m_rdata_o cycle 3; GAP_CYCLES idle cycles follow.
// Backpr. : masters hold m_req_i until m_ack_o; requests are not sampled while BUSY or during the post-ack gap.
//
// Ports   : clk_i/reset_ni (async active-low); m_req_i/m_cmd_i/m_wdata_i per-master request side;
//           m_rdata_o/m_ack_o/m_err_o per-master completion (rdata non-zero only in the ack cycle);
//           s_req_o/s_cmd_o/s_wdata_o/s_rdata_i/s_ack_i single slave-facing port.
// Option  : define ARB_TIMEOUT_EN to add a BUSY watchdog of TO_CYCLES cycles that completes with m_err_o.
module slave_rr_arbiter #(
    parameter int NM         = 4,
    parameter int DW         = 32,
    parameter int GAP_CYCLES = 2,
    parameter int TO_CYCLES  = 16
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic [NM-1:0]    m_req_i,
    input  logic [NM-1:0]    m_cmd_i,
    input  logic [NM*DW-1:0] m_wdata_i,
    output logic [NM*DW-1:0] m_rdata_o,
    output logic [NM-1:0]    m_ack_o,
    output logic [NM-1:0]    m_err_o,
    output logic             s_req_o,
    output logic             s_cmd_o,
    output logic [DW-1:0]    s_wdata_o,
    input  logic [DW-1:0]    s_rdata_i,
    input  logic             s_ack_i
);

    localparam int PW = (NM > 1) ? $clog2(NM) : 1;
    localparam int GW = $clog2(GAP_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [PW-1:0]     g_q, g_d;
    logic [GW-1:0]     gap_q, gap_d;
    logic              sreq_d;
    logic              cmd_d;
    logic [DW-1:0]     wdata_d;
    logic [NM-1:0]     ack_d;
    logic [NM*DW-1:0]  rdata_d;

    logic              grant_found;
    logic [PW-1:0]     grant_idx;
    logic [PW-1:0]     g_next;

`ifdef ARB_TIMEOUT_EN
    localparam int TW = $clog2(TO_CYCLES + 1);
    logic [TW-1:0]     to_q, to_d;
    logic [NM-1:0]     err_d;
`else
    // Timeout length only matters when the watchdog is built in.
    logic unused_to_cfg;
    assign unused_to_cfg = (TO_CYCLES > 0);
    assign m_err_o       = '0;
`endif

    // First requester at or above ptr, wrapping modulo NM.
    always_comb begin
        int idx;
        idx         = 0;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < NM; k++) begin
            idx = (int'(ptr_q) + k) % NM;
            if (!grant_found && m_req_i[idx]) begin
                grant_found = 1'b1;
                grant_idx   = PW'(idx);
            end
        end
    end

    // The just-served master drops to lowest priority.
    assign g_next = (g_q == PW'(NM - 1)) ? '0 : g_q + 1'b1;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        g_d     = g_q;
        gap_d   = gap_q;
        sreq_d  = 1'b0;
        cmd_d   = s_cmd_o;
        wdata_d = s_wdata_o;
        ack_d   = '0;
        rdata_d = '0;
`ifdef ARB_TIMEOUT_EN
        to_d    = to_q;
        err_d   = '0;
`endif
        case (state_q)
            IDLE: begin
                if (grant_found) begin
                    g_d     = grant_idx;
                    cmd_d   = m_cmd_i[grant_idx];
                    wdata_d = m_wdata_i[grant_idx*DW +: DW];
                    sreq_d  = 1'b1;
                    state_d = BUSY;
`ifdef ARB_TIMEOUT_EN
                    to_d    = '0;
`endif
                end
            end
            BUSY: begin
                sreq_d = 1'b1;
                // An ack arriving on the expiry cycle takes precedence over the timeout.
                if (s_ack_i) begin
                    ack_d[g_q] = 1'b1;
                    if (!s_cmd_o) begin
                        rdata_d[g_q*DW +: DW] = s_rdata_i;
                    end
                    ptr_d   = g_next;
                    sreq_d  = 1'b0;
                    gap_d   = '0;
                    state_d = GAP;
                end
`ifdef ARB_TIMEOUT_EN
                else if (to_q == TW'(TO_CYCLES - 1)) begin
                    ack_d[g_q] = 1'b1;
                    err_d[g_q] = 1'b1;
                    ptr_d      = g_next;
                    sreq_d     = 1'b0;
                    gap_d      = '0;
                    state_d    = GAP;
                end else begin
                    to_d = to_q + 1'b1;
                end
`endif
            end
            GAP: begin
                // Keeps s_req_o low long enough for the slave's ack edge detector to clear.
                if (gap_q == GW'(GAP_CYCLES - 1)) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            g_q       <= '0;
            gap_q     <= '0;
            s_req_o   <= 1'b0;
            s_cmd_o   <= 1'b0;
            s_wdata_o <= '0;
            m_ack_o   <= '0;
            m_rdata_o <= '0;
`ifdef ARB_TIMEOUT_EN
            to_q      <= '0;
            m_err_o   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            g_q       <= g_d;
            gap_q     <= gap_d;
            s_req_o   <= sreq_d;
            s_cmd_o   <= cmd_d;
            s_wdata_o <= wdata_d;
            m_ack_o   <= ack_d;
            m_rdata_o <= rdata_d;
`ifdef ARB_TIMEOUT_EN
            to_q      <= to_d;
            m_err_o   <= err_d;
`endif
        end
    end

endmodule

// File: tb/tb_slave_rr_arbiter.sv
// Purpose : directed bench for slave_rr_arbiter with a behavioural single-register slave and an ack scoreboard.
// Latency : checks request-to-ack latency of 3 cycles and 5-cycle spacing between slave requests.
// Backpr. : masters optionally drop their request in the cycle their ack is seen.
`define CHK(tag, obs, exp) begin ncomp++; assert ((obs) === (exp)) else begin nfail++; $error("FAIL %s: got %0h want %0h", tag, (obs), (exp)); end end

module tb_slave_rr_arbiter;

    localparam int NM = 4;
    localparam int DW = 32;

    logic             clk_i;
    logic             reset_ni;
    logic [NM-1:0]    m_req_i;
    logic [NM-1:0]    m_cmd_i;
    logic [NM*DW-1:0] m_wdata_i;
    logic [NM*DW-1:0] m_rdata_o;
    logic [NM-1:0]    m_ack_o;
    logic [NM-1:0]    m_err_o;
    logic             s_req_o;
    logic             s_cmd_o;
    logic [DW-1:0]    s_wdata_o;
    logic [DW-1:0]    s_rdata_i;
    logic             s_ack_i;

    slave_rr_arbiter #(.NM(NM), .DW(DW), .GAP_CYCLES(2), .TO_CYCLES(16)) dut (
        .clk_i     (clk_i),
        .reset_ni  (reset_ni),
        .m_req_i   (m_req_i),
        .m_cmd_i   (m_cmd_i),
        .m_wdata_i (m_wdata_i),
        .m_rdata_o (m_rdata_o),
        .m_ack_o   (m_ack_o),
        .m_err_o   (m_err_o),
        .s_req_o   (s_req_o),
        .s_cmd_o   (s_cmd_o),
        .s_wdata_o (s_wdata_o),
        .s_rdata_i (s_rdata_i),
        .s_ack_i   (s_ack_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        int            idx;
        logic [DW-1:0] rdata;
    } exp_t;

    exp_t          exp_q[$];
    int            rise_q[$];
    logic [DW-1:0] wr_log[$];

    int            ncomp = 0;
    int            nfail = 0;
    int            cyc = 0;
    int            last_ack_cyc = -1;
    int            gap_chk = 0;
    int            c0;
    bit            auto_drop = 1'b1;
    bit            force_ack = 1'b0;
    logic          prev_req = 1'b0;
    logic          prev_ack = 1'b0;
    logic          prev_sreq = 1'b0;
    logic [DW-1:0] mem = '0;

    // Advance one cycle, check the DUT outputs of the new cycle, then play the slave for it.
    task automatic tick();
        exp_t             e;
        logic [NM-1:0]    exp_ack;
        logic [NM*DW-1:0] exp_rd;
        logic             ack;
        @(posedge clk_i);
        #1;
        cyc++;
        if (s_req_o && !prev_sreq) rise_q.push_back(cyc);
        prev_sreq = s_req_o;
        if (gap_chk > 0) begin
            `CHK("gap_sreq_low", s_req_o, 1'b0)
            gap_chk--;
        end
        `CHK("err_zero", m_err_o, {NM{1'b0}})
        if (m_ack_o != '0) begin
            if (exp_q.size() == 0) begin
                ncomp++;
                nfail++;
                $error("FAIL unexpected_ack: got %0h want 0", m_ack_o);
            end else begin
                e       = exp_q.pop_front();
                exp_ack = '0;
                exp_ack[e.idx] = 1'b1;
                exp_rd  = '0;
                exp_rd[e.idx*DW +: DW] = e.rdata;
                `CHK("ack_grant", m_ack_o, exp_ack)
                `CHK("ack_rdata", m_rdata_o, exp_rd)
            end
            last_ack_cyc = cyc;
            if (auto_drop) m_req_i = m_req_i & ~m_ack_o;
        end else begin
            `CHK("rdata_idle_zero", m_rdata_o, {NM*DW{1'b0}})
        end
        // Slave: acks one cycle after seeing a request, single pulse, held off while its ack edge is set.
        ack = force_ack || (reset_ni && prev_req && !prev_ack);
        s_ack_i = ack;
        if (ack && s_cmd_o && s_req_o) begin
            mem = s_wdata_o;
            wr_log.push_back(s_wdata_o);
        end
        s_rdata_i = (ack && !s_cmd_o) ? mem : 32'hA5A5_A5A5;
        if (ack) gap_chk = 2;
        prev_req = s_req_o;
        prev_ack = ack;
    endtask

    task automatic wait_drain(input int budget, input string tag);
        for (int i = 0; i < budget && exp_q.size() > 0; i++) tick();
        if (exp_q.size() > 0) begin
            ncomp++;
            nfail++;
            $error("FAIL %s: %0d acks outstanding, want 0", tag, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        reset_ni  = 1'b0;
        m_req_i   = '0;
        m_cmd_i   = '0;
        m_wdata_i = '0;
        s_rdata_i = '0;
        s_ack_i   = 1'b0;

        // Reset state
        tick();
        tick();
        `CHK("rst_sreq", s_req_o, 1'b0)
        `CHK("rst_scmd", s_cmd_o, 1'b0)
        `CHK("rst_swdata", s_wdata_o, 32'h0)
        `CHK("rst_mack", m_ack_o, 4'h0)
        `CHK("rst_mrdata", m_rdata_o, {NM*DW{1'b0}})
        reset_ni = 1'b1;
        tick();
        tick();

        // Single write by master 0
        m_cmd_i   = 4'b0001;
        m_wdata_i[0*DW +: DW] = 32'hDEAD_BEEF;
        m_req_i   = 4'b0001;
        exp_q.push_back('{0, 32'h0});
        c0 = cyc;
        tick();
        `CHK("wr_sreq_c1", s_req_o, 1'b1)
        `CHK("wr_scmd", s_cmd_o, 1'b1)
        `CHK("wr_swdata", s_wdata_o, 32'hDEAD_BEEF)
        tick();
        `CHK("wr_sreq_c2", s_req_o, 1'b1)
        tick();
        `CHK("wr_mack_c3", m_ack_o, 4'b0001)
        `CHK("wr_sreq_c3", s_req_o, 1'b0)
        `CHK("wr_ack_lat", last_ack_cyc - c0, 3)
        repeat (3) tick();

        // Read by master 2 returns the stored word
        m_cmd_i = 4'b0000;
        m_req_i = 4'b0100;
        exp_q.push_back('{2, 32'hDEAD_BEEF});
        c0 = cyc;
        wait_drain(10, "rd_timeout");
        `CHK("rd_ack_lat", last_ack_cyc - c0, 3)
        repeat (3) tick();

        // Reset in the slave-ack cycle aborts master 3's read; then master 0 beats master 3
        m_req_i = 4'b1000;
        tick();
        tick();
        reset_ni = 1'b0;
        m_req_i  = '0;
        #1;
        `CHK("mrst_sreq", s_req_o, 1'b0)
        `CHK("mrst_scmd", s_cmd_o, 1'b0)
        `CHK("mrst_swdata", s_wdata_o, 32'h0)
        `CHK("mrst_mack", m_ack_o, 4'h0)
        `CHK("mrst_mrdata", m_rdata_o, {NM*DW{1'b0}})
        tick();
        `CHK("mrst_mack_next", m_ack_o, 4'h0)
        tick();
        reset_ni = 1'b1;
        tick();
        wr_log.delete();
        m_cmd_i = 4'b1001;
        m_wdata_i[0*DW +: DW] = 32'h1111_1111;
        m_wdata_i[3*DW +: DW] = 32'h3333_3333;
        m_req_i = 4'b1001;
        exp_q.push_back('{0, 32'h0});
        exp_q.push_back('{3, 32'h0});
        wait_drain(20, "mrst_timeout");
        `CHK("mrst_nwrites", wr_log.size(), 2)
        if (wr_log.size() == 2) begin
            `CHK("mrst_first_m0", wr_log[0], 32'h1111_1111)
            `CHK("mrst_second_m3", wr_log[1], 32'h3333_3333)
        end
        repeat (3) tick();

        // All four masters request continuously: grants 0,1,2,3,0 every 5 cycles
        auto_drop = 1'b0;
        rise_q.delete();
        wr_log.delete();
        m_cmd_i = 4'b1111;
        for (int i = 0; i < NM; i++) m_wdata_i[i*DW +: DW] = 32'hC0DE_0000 + i;
        m_req_i = 4'b1111;
        for (int i = 0; i < 5; i++) exp_q.push_back('{i % NM, 32'h0});
        wait_drain(40, "all4_timeout");
        m_req_i   = '0;
        auto_drop = 1'b1;
        repeat (4) tick();
        `CHK("all4_nrise", rise_q.size(), 5)
        for (int i = 1; i < rise_q.size(); i++) `CHK("all4_spacing", rise_q[i] - rise_q[i-1], 5)
        `CHK("all4_nwrites", wr_log.size(), 5)
        for (int i = 0; i < wr_log.size(); i++) `CHK("all4_wdata", wr_log[i], 32'hC0DE_0000 + (i % NM))

        // Spurious slave ack while idle: nothing happens, then normal service resumes at master 1
        force_ack = 1'b1;
        tick();
        force_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            `CHK("spur_no_ack", m_ack_o, 4'h0)
            `CHK("spur_no_sreq", s_req_o, 1'b0)
        end
        m_cmd_i = 4'b0000;
        m_req_i = 4'b0110;
        exp_q.push_back('{1, 32'hC0DE_0000});
        exp_q.push_back('{2, 32'hC0DE_0000});
        wait_drain(20, "spur_timeout");
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
        $finish;
    end

endmodule
